multiply_add_unit: RTL and testbench
====================================

// Module: multiply_add_unit
// PURPOSE
//  Radix-2 FFT butterfly: Y = A + w*B, Z = A - w*B on packed complex fixed-point words.
//  Sits in each FFT stage between the stage shift-register/reorder buffer and the next stage.
//  Twiddle w comes from the twiddle ROM; A/B are the butterfly input pair.
//  One result pair is registered per clock.
// PARAMETERS
//  DATA_W  16  bits per real/imag component; the port word is 2*DATA_W.
//  FRAC_W  15  fraction bits of w (Q1.15); the product is scaled by 2^-FRAC_W.
// PORTS
//  Clk  in   1         rising-edge clock
//  Rst  in   1         asynchronous, active-high reset
//  A    in   2*DATA_W  complex input A: [31:16] real, [15:0] imag, signed two's complement
//  B    in   2*DATA_W  complex input B, same format as A
//  w    in   2*DATA_W  twiddle: [31:16] real, [15:0] imag, signed Q1.15
//  Y    out  2*DATA_W  registered A + w*B, same packing as A
//  Z    out  2*DATA_W  registered A - w*B, same packing as A
// BEHAVIOUR
//  - One clock domain (Clk); reset is asynchronous and active-high (Rst).
//  - Rst=1 forces Y=0 and Z=0 immediately, with no clock edge needed.
//    This includes reset asserted mid-operation.
//  - After Rst deasserts, the first rising edge loads a valid result.
//  - A, B and w are sampled on the rising edge; Y/Z update on that same edge.
//    Latency is 1 cycle and throughput is 1 pair/cycle. There is no handshake and no enable.
//  - Product P = w*B, computed with full-precision signed multiplies (2*DATA_W-bit partials):
//      Pr_full = wr*br - wi*bi
//      Pi_full = wr*bi + wi*br
//    Hold the sums in a 2*DATA_W+1-bit signed accumulator so -32768*-32768 terms cannot overflow.
//  - Pr = Pr_full >>> FRAC_W, arithmetic shift (truncation toward -inf, no rounding); same for Pi.
//    Keep DATA_W+2 bits.
//  - Yr = Ar + Pr, Yi = Ai + Pi, Zr = Ar - Pr, Zi = Ai - Pi, all computed at DATA_W+3 bits.
//    The result is then narrowed to DATA_W bits per the CONFIGURATION rule.
//  - Real and imag lanes are independent; overflow in one lane never affects the other.
//  - No internal state besides the Y/Z output registers.
// CONFIGURATION
//  MAU_SATURATE_EN undefined: narrowing keeps the low DATA_W bits (two's-complement wrap).
//  MAU_SATURATE_EN defined:
//   - Each lane clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1], i.e. [0x8000, 0x7FFF].
//   - Clamping applies to each of the four Y/Z components.
//   - Latency is unchanged.
// STRUCTURE
//  - Package mau_pkg holds: localparams DATA_W and FRAC_W, a cplx_t packed struct {real, imag}, and SAT_MAX/SAT_MIN constants.
//    It also holds the narrow/saturate function, shared with other FFT stage blocks.
//  - Sub-module complex_mult: combinational w*B producing the Pr/Pi full-precision products and the shift.
//  - The top level does the add/subtract, narrowing, and output registers.
// TESTING
//  1) Rst=1 with arbitrary inputs, no clock -> Y=0x0000_0000, Z=0x0000_0000 immediately.
//  2) w=0x7FFF_0000, A=0x1000_0200, B=0x0800_0100, one edge -> Y=0x17FF_02FF, Z=0x0801_0101.
//     This checks truncation.
//  3) w=0x0000_8000 (-j), A=0, B=0x0800_0100 -> Y=0x0100_F800, Z=0xFF00_0800.
//  4) w=0x7FFF_0000, A=0x7000_0000, B=0x4000_0000 -> Z=0x3001_0000, and Y depends on the macro:
//     - Y=0xAFFF_0000 without MAU_SATURATE_EN
//     - Y=0x7FFF_0000 with it
//  5) Vector 2 then vector 3 on consecutive edges -> Y/Z show each result exactly 1 cycle after its inputs.
//     Then pulse Rst between edges -> outputs go 0 asynchronously.
//     The next edge after release reloads the current result.
//  6) w=0x8000_8000, B=0x8000_8000, A=0 -> Pr=0, Pi=0x10000 wraps/saturates per the macro:
//     - Y imag 0x0000 without MAU_SATURATE_EN
//     - Y imag 0x7FFF with it
//     - Z imag 0x0000 / 0x8000 respectively
//     This checks accumulator width.

Source files
------------

// File: rtl/mau_pkg.sv
// Shared types and narrowing helper for the FFT butterfly datapath.
// MAU_SATURATE_EN selects clamping instead of two's-complement wrap in narrow().
package mau_pkg;
  localparam int DATA_W = 16;
  localparam int FRAC_W = 15;
  localparam int ACC_W  = 2*DATA_W+1;
  localparam int PROD_W = DATA_W+2;
  localparam int SUM_W  = DATA_W+3;

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;

  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  function automatic logic [DATA_W-1:0] narrow(input logic signed [SUM_W-1:0] x);
`ifdef MAU_SATURATE_EN
    // bits above the result sign must all match it, otherwise the lane overflowed
    if (!x[SUM_W-1] && (|x[SUM_W-2:DATA_W-1]))
      return SAT_MAX;
    else if (x[SUM_W-1] && !(&x[SUM_W-2:DATA_W-1]))
      return SAT_MIN;
    else
      return x[DATA_W-1:0];
`else
    return DATA_W'(x);
`endif
  endfunction
endpackage

// File: rtl/complex_mult.sv
// Combinational w*B: full-precision partials, wide accumulate, arithmetic shift by FRAC_W.
module complex_mult
  import mau_pkg::*;
(
  input  cplx_t                    w,
  input  cplx_t                    b,
  output logic signed [PROD_W-1:0] pr,
  output logic signed [PROD_W-1:0] pi
);
  logic signed [2*DATA_W-1:0] rr, ii, ri, ir;
  logic signed [ACC_W-1:0]    pr_full, pi_full;

  assign rr = $signed(w.re) * $signed(b.re);
  assign ii = $signed(w.im) * $signed(b.im);
  assign ri = $signed(w.re) * $signed(b.im);
  assign ir = $signed(w.im) * $signed(b.re);

  // one extra bit: (-2^15)^2 + (-2^15)^2 = 2^31 does not fit in 2*DATA_W signed
  assign pr_full = $signed({rr[2*DATA_W-1], rr}) - $signed({ii[2*DATA_W-1], ii});
  assign pi_full = $signed({ri[2*DATA_W-1], ri}) + $signed({ir[2*DATA_W-1], ir});

  assign pr = PROD_W'(pr_full >>> FRAC_W);
  assign pi = PROD_W'(pi_full >>> FRAC_W);
endmodule

// File: rtl/multiply_add_unit.sv
// Radix-2 butterfly Y = A + w*B, Z = A - w*B, registered, 1-cycle latency.
// Narrowing follows MAU_SATURATE_EN (see mau_pkg::narrow).
module multiply_add_unit
  import mau_pkg::*;
(
  input  logic                Clk,
  input  logic                Rst,
  input  logic [2*DATA_W-1:0] A,
  input  logic [2*DATA_W-1:0] B,
  input  logic [2*DATA_W-1:0] w,
  output logic [2*DATA_W-1:0] Y,
  output logic [2*DATA_W-1:0] Z
);
  cplx_t                    a, b, tw;
  logic signed [PROD_W-1:0] pr, pi;
  logic signed [SUM_W-1:0]  ar_x, ai_x, pr_x, pi_x;
  logic signed [SUM_W-1:0]  yr, yi, zr, zi;

  assign a  = A;
  assign b  = B;
  assign tw = w;

  complex_mult u_cmul (
    .w  (tw),
    .b  (b),
    .pr (pr),
    .pi (pi)
  );

  assign ar_x = SUM_W'($signed(a.re));
  assign ai_x = SUM_W'($signed(a.im));
  assign pr_x = SUM_W'(pr);
  assign pi_x = SUM_W'(pi);

  assign yr = ar_x + pr_x;
  assign yi = ai_x + pi_x;
  assign zr = ar_x - pr_x;
  assign zi = ai_x - pi_x;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Y <= '0;
      Z <= '0;
    end else begin
      Y <= {narrow(yr), narrow(yi)};
      Z <= {narrow(zr), narrow(zi)};
    end
  end
endmodule

// File: tb/tb_multiply_add_unit.sv
// Bench for multiply_add_unit: vector table, hand sequences, random vectors against a model.
module tb_multiply_add_unit;
  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic [31:0] A = '0, B = '0, w = '0;
  logic [31:0] Y, Z;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a, b, w, ey, ez;
  } vec_t;

  typedef struct {
    logic [31:0] ey, ez;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[6];

  multiply_add_unit dut (
    .Clk (Clk),
    .Rst (Rst),
    .A   (A),
    .B   (B),
    .w   (w),
    .Y   (Y),
    .Z   (Z)
  );

  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %08h want %08h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] nar(input longint x);
`ifdef MAU_SATURATE_EN
    if (x > 32767) return 16'h7FFF;
    if (x < -32768) return 16'h8000;
`endif
    return x[15:0];
  endfunction

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ww);
    longint ar, ai, br, bi, wr, wi, pr, pi;
    exp_t e;
    ar = longint'($signed(a[31:16]));  ai = longint'($signed(a[15:0]));
    br = longint'($signed(b[31:16]));  bi = longint'($signed(b[15:0]));
    wr = longint'($signed(ww[31:16])); wi = longint'($signed(ww[15:0]));
    pr = (wr*br - wi*bi) >>> 15;
    pi = (wr*bi + wi*br) >>> 15;
    e.ey = {nar(ar + pr), nar(ai + pi)};
    e.ez = {nar(ar - pr), nar(ai - pi)};
    return e;
  endfunction

  // Drive one input set, expect its result right after the next edge.
  task automatic apply(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ww, input logic [31:0] ey, input logic [31:0] ez);
    exp_t e;
    A = a; B = b; w = ww;
    e.ey = ey; e.ez = ez;
    sb.push_back(e);
    @(posedge Clk);
    #1;
    e = sb.pop_front();
    check({name, ".Y"}, Y, e.ey);
    check({name, ".Z"}, Z, e.ez);
  endtask

  initial begin
    exp_t m;
    tbl[0] = '{32'h1000_0200, 32'h0800_0100, 32'h7FFF_0000, 32'h17FF_02FF, 32'h0801_0101};
    tbl[1] = '{32'h0000_0000, 32'h0800_0100, 32'h0000_8000, 32'h0100_F800, 32'hFF00_0800};
    tbl[2] = '{32'h1234_ABCD, 32'h5555_AAAA, 32'h0000_0000, 32'h1234_ABCD, 32'h1234_ABCD};
`ifdef MAU_SATURATE_EN
    tbl[3] = '{32'h7000_0000, 32'h4000_0000, 32'h7FFF_0000, 32'h7FFF_0000, 32'h3001_0000};
    tbl[4] = '{32'h0000_0000, 32'h8000_8000, 32'h8000_8000, 32'h0000_7FFF, 32'h0000_8000};
    tbl[5] = '{32'h8000_0000, 32'h8000_8000, 32'h7FFF_0000, 32'h8000_8001, 32'hFFFF_7FFF};
`else
    tbl[3] = '{32'h7000_0000, 32'h4000_0000, 32'h7FFF_0000, 32'hAFFF_0000, 32'h3001_0000};
    tbl[4] = '{32'h0000_0000, 32'h8000_8000, 32'h8000_8000, 32'h0000_0000, 32'h0000_0000};
    tbl[5] = '{32'h8000_0000, 32'h8000_8000, 32'h7FFF_0000, 32'h0001_8001, 32'hFFFF_7FFF};
`endif

    // async reset with no clock edge yet
    A = 32'hDEAD_BEEF; B = 32'h1234_5678; w = 32'h7FFF_7FFF;
    #1 Rst = 1'b1;
    #1;
    check("rst_noclk.Y", Y, 32'h0);
    check("rst_noclk.Z", Z, 32'h0);
    @(negedge Clk);
    Rst = 1'b0;

    for (int i = 0; i < 6; i++)
      apply($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].w, tbl[i].ey, tbl[i].ez);

    // back-to-back: outputs hold until the edge, then show the new result
    apply("seq_v2", tbl[0].a, tbl[0].b, tbl[0].w, tbl[0].ey, tbl[0].ez);
    A = tbl[1].a; B = tbl[1].b; w = tbl[1].w;
    #2;
    check("seq_hold.Y", Y, tbl[0].ey);
    check("seq_hold.Z", Z, tbl[0].ez);
    @(posedge Clk);
    #1;
    check("seq_v3.Y", Y, tbl[1].ey);
    check("seq_v3.Z", Z, tbl[1].ez);

    // reset pulse between edges, then reload of current inputs
    @(negedge Clk);
    Rst = 1'b1;
    #1;
    check("rst_mid.Y", Y, 32'h0);
    check("rst_mid.Z", Z, 32'h0);
    #1 Rst = 1'b0;
    #1;
    check("rst_hold.Y", Y, 32'h0);
    @(posedge Clk);
    #1;
    check("reload.Y", Y, tbl[1].ey);
    check("reload.Z", Z, tbl[1].ez);

    for (int i = 0; i < 24; i++) begin
      logic [31:0] ra, rb, rw;
      ra = $urandom; rb = $urandom; rw = $urandom;
      if (i < 4) begin
        rb = {16'h8000, rb[15:0]};
        rw = {rw[31:16], 16'h8000};
      end
      m = model(ra, rb, rw);
      apply($sformatf("rnd%0d", i), ra, rb, rw, m.ey, m.ez);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
